// File: rtl/obj_oam_pkg.sv
// Shared types, constants and address helper for the OAM responder block.
package obj_oam_pkg;

    typedef enum logic [1:0] {
        OAM_BYTE = 2'd0,
        OAM_HALF = 2'd1,
        OAM_WORD = 2'd2
    } oam_size_t;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } oam_state_t;

    localparam int OAM_LINES_VISIBLE = 160;
    localparam int OAM_BYTES         = 1024;

    // Byte address -> word index, wrapped into the table size.
    function automatic int unsigned oam_word_index(input logic [9:0] byte_addr,
                                                   input int unsigned words);
        return {24'd0, byte_addr[9:2]} % words;
    endfunction

endpackage

// File: rtl/obj_oam_responder_if.sv
// CPU/MMIO request-acknowledge bus into the OAM responder.
interface obj_oam_responder_if;
    import obj_oam_pkg::*;

    localparam int CPU_AW = $clog2(OAM_BYTES);

    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic [CPU_AW-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );

endinterface

// File: rtl/obj_oam_ram.sv
// Dual-port OAM storage: port A read-only, port B read/write with byte enables.
// Both ports have registered, read-first outputs.
module obj_oam_ram #(
    parameter int WORDS = 256,
    localparam int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             a_clr,
    input  logic [IDX_W-1:0] a_addr,
    output logic [31:0]      a_rdata,
    input  logic             b_en,
    input  logic [3:0]       b_we,
    input  logic [IDX_W-1:0] b_addr,
    input  logic [31:0]      b_wdata,
    output logic [31:0]      b_rdata
);

    // One byte-wide array per lane so each byte enable maps to its own RAM column.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [WORDS];
        logic [7:0] a_q_reg;
        logic [7:0] b_q_reg;

        always_ff @(posedge clk) begin
            if (b_we[gi]) begin
                mem[b_addr] <= b_wdata[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (srst || a_clr) begin
                a_q_reg <= '0;
            end else begin
                a_q_reg <= mem[a_addr];
            end
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                b_q_reg <= '0;
            end else if (b_en) begin
                b_q_reg <= mem[b_addr];
            end
        end

        assign a_rdata[gi*8 +: 8] = a_q_reg;
        assign b_rdata[gi*8 +: 8] = b_q_reg;
    end

endmodule

// File: rtl/obj_oam_responder.sv
// OAM table with object-engine read port and CPU request/ack port (GBA write rules).
// Optional render lock stalling CPU access during active display: OAM_RENDER_LOCK_EN.
module obj_oam_responder
    import obj_oam_pkg::*;
#(
    parameter int OAM_WORDS      = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         OAM_mem_addr,
    output logic [31:0]         OAM_mem_data,
    obj_oam_responder_if.slave  cpu,
    output logic                init_busy,
    input  logic [15:0]         dispcnt,
    input  logic [7:0]          vcount,
    input  logic                hblank
);

    localparam int IDX_W = $clog2(OAM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OAM_WORDS - 1);
    localparam oam_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    oam_state_t       state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             we_reg, we_next;
    logic [1:0]       size_reg, size_next;
    logic [9:0]       addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;

    logic             stall;
    logic [IDX_W-1:0] eng_idx;
    logic [IDX_W-1:0] acc_idx;
    logic             ram_b_en;
    logic [3:0]       ram_b_we;
    logic [IDX_W-1:0] ram_b_addr;
    logic [31:0]      ram_b_wdata;

    logic unused_inputs;
    assign unused_inputs = ^{OAM_mem_addr[31:10], dispcnt, vcount, hblank};

`ifdef OAM_RENDER_LOCK_EN
    assign stall = (vcount < 8'(OAM_LINES_VISIBLE)) && !hblank && !dispcnt[5] && !dispcnt[7];
`else
    assign stall = 1'b0;
`endif

    assign eng_idx = IDX_W'(oam_word_index(OAM_mem_addr[9:0], OAM_WORDS));
    assign acc_idx = IDX_W'(oam_word_index(addr_reg, OAM_WORDS));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            size_reg  <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            size_reg  <= size_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        we_next     = we_reg;
        size_next   = size_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        ram_b_en    = 1'b0;
        ram_b_we    = '0;
        ram_b_addr  = acc_idx;
        ram_b_wdata = wdata_reg;

        case (state_reg)
            CLEAR: begin
                ram_b_we    = 4'hF;
                ram_b_addr  = cnt_reg;
                ram_b_wdata = '0;
                cnt_next    = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (cpu.cpu_req && !stall) begin
                    we_next    = cpu.cpu_we;
                    size_next  = cpu.cpu_size;
                    addr_next  = cpu.cpu_addr;
                    wdata_next = cpu.cpu_wdata;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Port B always reads here so a write ack returns the pre-write word.
                ram_b_en = 1'b1;
                if (we_reg) begin
                    case (size_reg)
                        OAM_BYTE: ram_b_we = 4'h0;
                        OAM_HALF: begin
                            ram_b_we    = addr_reg[1] ? 4'b1100 : 4'b0011;
                            ram_b_wdata = {wdata_reg[15:0], wdata_reg[15:0]};
                        end
                        default:  ram_b_we = 4'hF;
                    endcase
                end
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (reset) begin
            ram_b_we = '0;
        end
    end

    obj_oam_ram #(
        .WORDS (OAM_WORDS)
    ) u_ram (
        .clk     (clock),
        .srst    (reset),
        .a_clr   (state_reg == CLEAR),
        .a_addr  (eng_idx),
        .a_rdata (OAM_mem_data),
        .b_en    (ram_b_en),
        .b_we    (ram_b_we),
        .b_addr  (ram_b_addr),
        .b_wdata (ram_b_wdata),
        .b_rdata (cpu.cpu_rdata)
    );

    assign cpu.cpu_ack = (state_reg == RESP);
    assign init_busy   = (state_reg == CLEAR);

endmodule

// File: tb/tb_obj_oam_responder.sv
// Directed self-checking bench for obj_oam_responder.
module tb_obj_oam_responder;

    logic        clock;
    logic        reset;
    logic [31:0] OAM_mem_addr;
    logic [31:0] OAM_mem_data;
    logic        init_busy;
    logic [15:0] dispcnt;
    logic [7:0]  vcount;
    logic        hblank;

    int checks;
    int errors;

    obj_oam_responder_if cpu_bus ();

    obj_oam_responder #(
        .OAM_WORDS      (256),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .OAM_mem_addr (OAM_mem_addr),
        .OAM_mem_data (OAM_mem_data),
        .cpu          (cpu_bus),
        .init_busy    (init_busy),
        .dispcnt      (dispcnt),
        .vcount       (vcount),
        .hblank       (hblank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic eng_read(input logic [31:0] addr, output logic [31:0] data);
        OAM_mem_addr = addr;
        tick();
        data = OAM_mem_data;
        $display("eng  addr=%h data=%h", addr, data);
    endtask

    // Full CPU transaction; inputs are scrambled after acceptance.
    task automatic do_access(input logic we, input logic [1:0] size, input logic [9:0] addr,
                             input logic [31:0] wdata, output logic ack_early,
                             output logic ack_seen, output logic [31:0] rdata,
                             output logic ack_after);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_size  = size;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wdata;
        tick();
        ack_early = cpu_bus.cpu_ack;
        cpu_bus.cpu_we    = ~we;
        cpu_bus.cpu_size  = ~size;
        cpu_bus.cpu_addr  = addr ^ 10'h3FC;
        cpu_bus.cpu_wdata = ~wdata;
        tick();
        ack_seen = cpu_bus.cpu_ack;
        rdata    = cpu_bus.cpu_rdata;
        cpu_bus.cpu_req = 1'b0;
        tick();
        ack_after = cpu_bus.cpu_ack;
        $display("cpu  we=%0d size=%0d addr=%h wdata=%h ack=%0d rdata=%h",
                 we, size, addr, wdata, ack_seen, rdata);
    endtask

    task automatic test_reset();
        int cycles;
        logic [31:0] d;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (cpu_bus.cpu_ack !== 1'b0 || cpu_bus.cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_cpu: ack=%b rdata=%h required ack=0 rdata=0",
                     cpu_bus.cpu_ack, cpu_bus.cpu_rdata);
        end
        checks++;
        if (init_busy !== 1'b1 || OAM_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy: init_busy=%b data=%h required 1 / 0", init_busy, OAM_mem_data);
        end
        reset = 1'b0;
        cycles = 0;
        while (init_busy === 1'b1 && cycles < 1000) begin
            tick();
            cycles++;
        end
        $display("sweep busy_cycles=%0d", cycles);
        checks++;
        if (cycles != 256) begin
            errors++;
            $display("FAIL sweep_len: got %0d cycles required 256", cycles);
        end
        for (int i = 0; i < 4; i++) begin
            eng_read(32'(i * 252), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL sweep_zero[%0d]: got %h required 00000000", i, d);
            end
        end
    endtask

    task automatic test_word_write();
        logic e, s, a;
        logic [31:0] r, d;
        do_access(1'b1, 2'd2, 10'h008, 32'hDEADBEEF, e, s, r, a);
        checks++;
        if (e !== 1'b0 || s !== 1'b1 || a !== 1'b0) begin
            errors++;
            $display("FAIL word_ack_timing: early=%b at_n2=%b after=%b required 0 1 0", e, s, a);
        end
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL word_readfirst: rdata=%h required 00000000", r);
        end
        eng_read(32'h0000_0008, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_eng: got %h required DEADBEEF", d);
        end
        eng_read(32'hFFFF_F40B, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_eng_upper_ignored: got %h required DEADBEEF", d);
        end
    endtask

    task automatic test_sizes();
        logic e, s, a;
        logic [31:0] r, d;
        do_access(1'b1, 2'd1, 10'h00A, 32'hFFFF1234, e, s, r, a);
        eng_read(32'h8, d);
        checks++;
        if (d !== 32'h1234BEEF || r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL half_hi: word=%h rdata=%h required 1234BEEF / DEADBEEF", d, r);
        end
        do_access(1'b1, 2'd1, 10'h009, 32'hAAAA5678, e, s, r, a);
        eng_read(32'h8, d);
        checks++;
        if (d !== 32'h12345678) begin
            errors++;
            $display("FAIL half_lo: word=%h required 12345678", d);
        end
        do_access(1'b1, 2'd0, 10'h00A, 32'h00000055, e, s, r, a);
        eng_read(32'h8, d);
        checks++;
        if (d !== 32'h12345678 || s !== 1'b1) begin
            errors++;
            $display("FAIL byte_ignored: word=%h ack=%b required 12345678 ack=1", d, s);
        end
        do_access(1'b0, 2'd2, 10'h008, 32'h0, e, s, r, a);
        checks++;
        if (r !== 32'h12345678 || s !== 1'b1) begin
            errors++;
            $display("FAIL cpu_read: rdata=%h ack=%b required 12345678 ack=1", r, s);
        end
        do_access(1'b1, 2'd3, 10'h017, 32'h0BADF00D, e, s, r, a);
        eng_read(32'h14, d);
        checks++;
        if (d !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL size3_word: word=%h required 0BADF00D", d);
        end
    endtask

    task automatic test_collision();
        logic e, s, a;
        logic [31:0] r;
        do_access(1'b1, 2'd2, 10'h00C, 32'h11111111, e, s, r, a);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_size  = 2'd2;
        cpu_bus.cpu_addr  = 10'h00C;
        cpu_bus.cpu_wdata = 32'hCAFEF00D;
        OAM_mem_addr      = 32'h0;
        tick();
        OAM_mem_addr = 32'h0000_000C;
        tick();
        $display("cpu  collision write word3 ack=%0d eng_data=%h", cpu_bus.cpu_ack, OAM_mem_data);
        checks++;
        if (OAM_mem_data !== 32'h11111111 || cpu_bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL collide_old: data=%h ack=%b required 11111111 ack=1",
                     OAM_mem_data, cpu_bus.cpu_ack);
        end
        cpu_bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (OAM_mem_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL collide_new: data=%h required CAFEF00D", OAM_mem_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int acks;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_size  = 2'd2;
        cpu_bus.cpu_addr  = 10'h01C;
        cpu_bus.cpu_wdata = 32'hA5A5A5A5;
        tick();
        tick();
        checks++;
        if (cpu_bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_ack: ack=%b required 1", cpu_bus.cpu_ack);
        end
        cpu_bus.cpu_addr  = 10'h020;
        cpu_bus.cpu_wdata = 32'h5A5A5A5A;
        acks = 0;
        tick();
        acks += int'(cpu_bus.cpu_ack);
        tick();
        acks += int'(cpu_bus.cpu_ack);
        tick();
        $display("cpu  back-to-back second ack=%0d", cpu_bus.cpu_ack);
        checks++;
        if (acks != 0 || cpu_bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ack: early_acks=%0d ack=%b required 0 / 1", acks, cpu_bus.cpu_ack);
        end
        cpu_bus.cpu_req = 1'b0;
        tick();
        eng_read(32'h1C, d);
        checks++;
        if (d !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b_word7: got %h required A5A5A5A5", d);
        end
        eng_read(32'h20, d);
        checks++;
        if (d !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL b2b_word8: got %h required 5A5A5A5A", d);
        end
    endtask

    task automatic test_reset_mid_access();
        logic e, s, a;
        logic [31:0] r, d;
        int cycles;
        int acks;
        do_access(1'b1, 2'd2, 10'h018, 32'h66666666, e, s, r, a);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_size  = 2'd2;
        cpu_bus.cpu_addr  = 10'h018;
        cpu_bus.cpu_wdata = 32'h77777777;
        tick();
        reset = 1'b1;
        tick();
        cpu_bus.cpu_req = 1'b0;
        reset = 1'b0;
        $display("cpu  reset during ACCESS busy=%0d ack=%0d", init_busy, cpu_bus.cpu_ack);
        checks++;
        if (cpu_bus.cpu_ack !== 1'b0 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: ack=%b busy=%b required 0 / 1", cpu_bus.cpu_ack, init_busy);
        end
        cycles = 0;
        acks = 0;
        while (init_busy === 1'b1 && cycles < 1000) begin
            tick();
            acks += int'(cpu_bus.cpu_ack);
            cycles++;
        end
        checks++;
        if (cycles != 256 || acks != 0) begin
            errors++;
            $display("FAIL midreset_sweep: cycles=%0d acks=%0d required 256 / 0", cycles, acks);
        end
        eng_read(32'h18, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midreset_word: got %h required 00000000", d);
        end
    endtask

`ifdef OAM_RENDER_LOCK_EN
    task automatic test_render_lock();
        int acks;
        vcount  = 8'd50;
        hblank  = 1'b0;
        dispcnt = 16'h0000;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_size  = 2'd2;
        cpu_bus.cpu_addr  = 10'h024;
        cpu_bus.cpu_wdata = 32'h99990000;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(cpu_bus.cpu_ack);
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL lock_stall: acks=%0d required 0", acks);
        end
        hblank = 1'b1;
        tick();
        tick();
        $display("cpu  lock released by hblank ack=%0d", cpu_bus.cpu_ack);
        checks++;
        if (cpu_bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_hblank: ack=%b required 1", cpu_bus.cpu_ack);
        end
        cpu_bus.cpu_req = 1'b0;
        hblank = 1'b0;
        tick();
        dispcnt = 16'h0080;
        cpu_bus.cpu_req = 1'b1;
        tick();
        tick();
        $display("cpu  forced blank ack=%0d", cpu_bus.cpu_ack);
        checks++;
        if (cpu_bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL lock_forced_blank: ack=%b required 1", cpu_bus.cpu_ack);
        end
        cpu_bus.cpu_req = 1'b0;
        dispcnt = 16'h0000;
        vcount  = 8'd200;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        OAM_mem_addr      = 32'h0;
        dispcnt           = 16'h0;
        vcount            = 8'd200;
        hblank            = 1'b0;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_size  = 2'd0;
        cpu_bus.cpu_addr  = 10'h0;
        cpu_bus.cpu_wdata = 32'h0;

        test_reset();
        test_word_write();
        test_sizes();
        test_collision();
        test_back_to_back();
`ifdef OAM_RENDER_LOCK_EN
        test_render_lock();
`endif
        test_reset_mid_access();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
